stack_ctrl: RTL

Sequencer between the core's CALL/RET/PUSH/POP decode and the stack RAM. It turns one push or pop request into a RAM write or read, and drives inc/dec strobes to the stack pointer register. It consumes the current SP value to form the RAM address. It detects overflow and underflow against fixed stack bounds and returns pop data with a fixed latency.

---
 rtl/turtle_stack_pkg.sv | 20 ++
 rtl/stack_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/turtle_stack_pkg.sv
// Shared types and default widths for the stack sequencer.
// Holds the FSM state encoding and the push/pop operation encoding.
package turtle_stack_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PUSH     = 2'd1,
      POP_RD   = 2'd2,
      POP_WAIT = 2'd3
   } stack_state_e;

   typedef enum logic {
      OP_POP  = 1'b0,
      OP_PUSH = 1'b1
   } stack_op_e;

endpackage

// File: rtl/stack_ctrl.sv
// Push/pop sequencer between instruction decode and the stack RAM.
// Drives SP strobes, flags overflow/underflow, and returns pop data at N+2.
module stack_ctrl
   import turtle_stack_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int STACK_BASE  = 0,
   parameter int STACK_LIMIT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_push,
   input  logic [DATA_W-1:0] req_data,
   output logic              req_ready,
   output logic              done,
   output logic [DATA_W-1:0] pop_data,
   output logic              err_ovf,
   output logic              err_unf,
   input  logic              err_clr,
   input  logic [ADDR_W-1:0] sp_val,
   output logic              sp_inc,
   output logic              sp_dec,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state
);

   localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(STACK_BASE);
   localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(STACK_LIMIT);

   stack_state_e      state_q, state_d;
   stack_op_e         req_op;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] pop_data_q;
   logic              rej_q, rej_d;
   logic              err_ovf_q, err_unf_q;
   logic              accept, ovf_set, unf_set;

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only while the FSM is idle,
   // and req_push/req_data need only be stable in that transfer cycle.
   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;
   assign req_op    = stack_op_e'(req_push);
   assign rej_d     = (req_op == OP_PUSH) ? (sp_val == LIMIT_A) : (sp_val == BASE_A);

   assign mem_wdata = data_q;
   assign err_ovf   = err_ovf_q;
   assign err_unf   = err_unf_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d  = state_q;
      done     = 1'b0;
      sp_inc   = 1'b0;
      sp_dec   = 1'b0;
      mem_we   = 1'b0;
      mem_re   = 1'b0;
      mem_addr = sp_val;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      pop_data = pop_data_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = (req_op == OP_PUSH) ? PUSH : POP_RD;
         end
         PUSH: begin
            done = 1'b1;
            if (rej_q) begin
               ovf_set = 1'b1;
            end else begin
               mem_we = 1'b1;
               sp_inc = 1'b1;
            end
            state_d = IDLE;
         end
         POP_RD: begin
            // SP points at the next free slot, so the top word sits one below.
            mem_addr = sp_val - ADDR_W'(1);
            if (rej_q) begin
               unf_set = 1'b1;
            end else begin
               mem_re = 1'b1;
               sp_dec = 1'b1;
            end
            state_d = POP_WAIT;
         end
         POP_WAIT: begin
            done     = 1'b1;
            pop_data = rej_q ? '0 : mem_rdata;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         data_q     <= '0;
         rej_q      <= 1'b0;
         pop_data_q <= '0;
         err_ovf_q  <= 1'b0;
         err_unf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            data_q <= req_data;
            rej_q  <= rej_d;
         end
         if (state_q == POP_WAIT) pop_data_q <= pop_data;
         // A new error outranks a clear arriving in the same cycle.
         if (ovf_set)      err_ovf_q <= 1'b1;
         else if (err_clr) err_ovf_q <= 1'b0;
         if (unf_set)      err_unf_q <= 1'b1;
         else if (err_clr) err_unf_q <= 1'b0;
      end
   end

endmodule
